// File: rtl/ahb_write_buffer_pkg.sv
// ahb_write_buffer_pkg: AHB-Lite encodings shared by the write buffer and its bench
package ahb_write_buffer_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    function automatic int hsize_bytes(input logic [2:0] size);
        return 1 << size;
    endfunction
endpackage

// File: rtl/ahb_write_buffer_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy level
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/ahb_write_buffer.sv
// ahb_write_buffer: posted-write buffer between an AHB-Lite master and a slower slave
module ahb_write_buffer
    import ahb_write_buffer_pkg::*;
#(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              src_hready_resp,
    input  logic              src_hready,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              dst_hready_resp,
    output logic              dst_hready,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata,
    output logic              posted_err
);
    localparam int W_ENT = W_ADDR + 3 + 4 + W_DATA;
    localparam int W_LVL = $clog2(DEPTH) + 1;
    typedef enum logic [1:0] {U_IDLE, U_WRITE, U_READ} u_state_t;
    typedef enum logic [1:0] {D_IDLE, D_WRITE, D_READ, D_RDONE} d_state_t;
    u_state_t          u_state;
    d_state_t          d_state;
    logic [W_ADDR-1:0] a_addr, h_addr;
    logic [2:0]        a_size, h_size;
    logic [3:0]        a_prot, h_prot;
    logic [W_DATA-1:0] h_data, wd, rd_data;
    logic [W_ENT-1:0]  head;
    logic [W_LVL-1:0]  count;
    logic              full, empty, push, pop, aphase, iss_wr, iss_rd;
    logic              unused_ok;
    assign aphase = src_hready && src_htrans[1];
    assign push   = u_state == U_WRITE && src_hready && src_hready_resp;
    assign pop    = d_state == D_WRITE && dst_hready_resp;
    assign iss_wr = d_state == D_IDLE && !empty;
    assign iss_rd = d_state == D_IDLE && empty && u_state == U_READ;
    assign {h_addr, h_size, h_prot, h_data} = head;
    assign unused_ok = ^{src_hburst, src_hmastlock, src_htrans[0], full};
    sync_fifo #(.WIDTH(W_ENT), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({a_addr, a_size, a_prot, src_hwdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (count)
    );
    // Address phase is presented straight from the FIFO head so a posted write reaches the slave one cycle after push
    always_comb begin
        dst_htrans      = iss_wr || iss_rd ? HTRANS_NONSEQ : HTRANS_IDLE;
        dst_hwrite      = iss_wr;
        dst_haddr       = iss_wr ? h_addr : iss_rd ? a_addr : '0;
        dst_hsize       = iss_wr ? h_size : iss_rd ? a_size : '0;
        dst_hprot       = iss_wr ? h_prot : iss_rd ? a_prot : '0;
        src_hready_resp = u_state == U_WRITE ? count < W_LVL'(DEPTH) :
                          u_state == U_READ  ? d_state == D_RDONE : 1'b1;
    end
    assign dst_hburst    = HBURST_SINGLE;
    assign dst_hmastlock = 1'b0;
    assign dst_hready    = dst_hready_resp;
    assign dst_hwdata    = wd;
    assign src_hrdata    = rd_data;
    assign src_hresp     = 1'b0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            u_state <= U_IDLE;
            a_addr  <= '0;
            a_size  <= '0;
            a_prot  <= '0;
        end else if (src_hready) begin
            u_state <= !aphase ? U_IDLE : src_hwrite ? U_WRITE : U_READ;
            if (aphase) begin
                a_addr <= src_haddr;
                a_size <= src_hsize;
                a_prot <= src_hprot;
            end
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            d_state    <= D_IDLE;
            wd         <= '0;
            rd_data    <= '0;
            posted_err <= 1'b0;
        end else begin
            posted_err <= pop && dst_hresp;
            case (d_state)
                D_IDLE:
                    if (dst_hready_resp && iss_wr) begin
                        d_state <= D_WRITE;
                        wd      <= h_data;
                    end else if (dst_hready_resp && iss_rd) d_state <= D_READ;
                D_WRITE: if (dst_hready_resp) d_state <= D_IDLE;
                D_READ:
                    if (dst_hready_resp) begin
                        rd_data <= dst_hrdata;
                        d_state <= D_RDONE;
                    end
                default: d_state <= D_IDLE;
            endcase
        end
endmodule

// File: tb/tb_ahb_write_buffer.sv
// tb_ahb_write_buffer: scoreboarded bench with a wait-state/error capable downstream slave
module tb_ahb_write_buffer;
    import ahb_write_buffer_pkg::*;
    typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} xfer_t;
    logic        clk = 0, rst_n = 0;
    logic        src_hready_resp, src_hready, src_hresp;
    logic [31:0] src_haddr = 0, src_hwdata = 0, src_hrdata;
    logic        src_hwrite = 0, src_hmastlock = 0;
    logic [1:0]  src_htrans = 0;
    logic [2:0]  src_hsize = 3'd2, src_hburst = 0;
    logic [3:0]  src_hprot = 4'h3;
    logic        dst_hready_resp = 1, dst_hready, dst_hresp = 0;
    logic [31:0] dst_haddr, dst_hwdata, dst_hrdata = 0;
    logic        dst_hwrite, dst_hmastlock, posted_err;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize, dst_hburst;
    logic [3:0]  dst_hprot;
    int          n_chk = 0, n_fail = 0;
    int          ws = 0, n_ap = 0, pe_hi = 0, hresp_bad = 0;
    bit          err_arm = 0;
    xfer_t       sb[$];
    logic [31:0] smem [logic [31:0]];
    logic        op_w [16];
    logic [31:0] op_a [16], op_d [16], rdv [16];
    int          wt [16];
    always #5 clk = ~clk;
    assign src_hready = src_hready_resp;
    ahb_write_buffer #(.W_ADDR(32), .W_DATA(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_hready_resp(src_hready_resp), .src_hready(src_hready), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
        .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .dst_hready_resp(dst_hready_resp), .dst_hready(dst_hready), .dst_hresp(dst_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
        .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata),
        .posted_err(posted_err)
    );
    // Downstream slave: ws wait states per transfer, two-cycle ERROR on writes while err_arm is set
    task automatic slave_loop();
        bit          dp_act = 0, dp_wr = 0, ap_v = 0, ap_w = 0, last_hr = 1, err_ph = 0;
        logic [31:0] dp_addr = 0, ap_a = 0;
        int          dp_cnt = 0;
        xfer_t       e;
        forever begin
            @(negedge clk);
            pe_hi += int'(posted_err);
            if (src_hresp !== 1'b0) hresp_bad++;
            if (!rst_n) begin
                dst_hready_resp = 1; dst_hresp = 0; dp_act = 0; ap_v = 0; last_hr = 1; err_ph = 0;
            end else begin
                if (last_hr) begin dp_act = ap_v; dp_wr = ap_w; dp_addr = ap_a; dp_cnt = ws; end
                dst_hready_resp = 1; dst_hresp = 0;
                if (dp_act) begin
                    if (dp_cnt > 0) begin dst_hready_resp = 0; dp_cnt--; end
                    else if (dp_wr && err_arm && !err_ph) begin dst_hready_resp = 0; dst_hresp = 1; err_ph = 1; end
                    else begin
                        if (err_ph) begin dst_hresp = 1; err_ph = 0; end
                        n_chk++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL dst_unexpected got w=%0b a=%08h want no transfer", dp_wr, dp_addr);
                        end else begin
                            e = sb.pop_front();
                            if (dp_wr !== e.w || dp_addr !== e.a || (dp_wr && dst_hwdata !== e.d)) begin
                                n_fail++;
                                $display("FAIL dst_order got w=%0b a=%08h d=%08h want w=%0b a=%08h d=%08h",
                                         dp_wr, dp_addr, dst_hwdata, e.w, e.a, e.d);
                            end
                        end
                        if (dp_wr) smem[dp_addr] = dst_hwdata;
                        else dst_hrdata = smem.exists(dp_addr) ? smem[dp_addr] : ~dp_addr;
                    end
                end
                ap_v = dst_htrans == HTRANS_NONSEQ; ap_w = dst_hwrite; ap_a = dst_haddr;
                if (ap_v && dst_hready_resp) n_ap++;
                last_hr = dst_hready_resp;
            end
        end
    endtask
    task automatic wait_ready(output int w, output logic [31:0] rd);
        w = 0;
        @(negedge clk);
        while (!src_hready && w < 200) begin w++; @(negedge clk); end
        rd = src_hrdata;
        if (w >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL src_ready_timeout got %0d cycles want < 200", w);
        end
        @(posedge clk); #1;
    endtask
    // Pipelined master: op i address phase overlaps op i-1 data phase
    task automatic run_ops(input int n);
        int w; logic [31:0] rd;
        for (int i = 0; i <= n; i++) begin
            src_htrans = i < n ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (i < n) begin
                src_hwrite = op_w[i]; src_haddr = op_a[i];
                sb.push_back('{op_w[i], op_a[i], op_d[i]});
            end
            if (i > 0 && op_w[i-1]) src_hwdata = op_d[i-1];
            wait_ready(w, rd);
            if (i > 0) begin wt[i-1] = w; rdv[i-1] = rd; end
        end
    endtask
    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin @(negedge clk); t++; end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL drain got %0d pending want 0", sb.size()); end
        repeat (3) @(posedge clk); #1;
    endtask
    task automatic test_reset();
        int base;
        rst_n = 0;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (src_hready_resp !== 1'b1) begin n_fail++; $display("FAIL rst_hready got %0b want 1", src_hready_resp); end
        n_chk++; if (dst_htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans got %0d want 0", dst_htrans); end
        n_chk++; if (posted_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", posted_err); end
        n_chk++; if (src_hrdata !== 32'h0) begin n_fail++; $display("FAIL rst_hrdata got %08h want 0", src_hrdata); end
        n_chk++; if ({dst_haddr, dst_hwdata, dst_hwrite} !== 65'h0) begin
            n_fail++; $display("FAIL rst_dst got a=%08h d=%08h w=%0b want 0", dst_haddr, dst_hwdata, dst_hwrite); end
        rst_n = 1;
        base = n_ap;
        repeat (5) @(posedge clk); #1;
        n_chk++; if (n_ap != base) begin n_fail++; $display("FAIL idle_activity got %0d want 0", n_ap - base); end
    endtask
    task automatic test_single_write();
        ws = 0;
        op_w[0] = 1; op_a[0] = 32'h1000; op_d[0] = 32'hDEADBEEF;
        run_ops(1);
        n_chk++; if (wt[0] != 0) begin n_fail++; $display("FAIL single_waits got %0d want 0", wt[0]); end
        n_chk++; if (dst_htrans !== HTRANS_NONSEQ || dst_haddr !== 32'h1000 || dst_hwrite !== 1'b1) begin
            n_fail++; $display("FAIL single_aphase got t=%0d a=%08h w=%0b want t=2 a=00001000 w=1", dst_htrans, dst_haddr, dst_hwrite); end
        n_chk++; if (dst_hsize !== 3'd2 || dst_hprot !== 4'h3 || dst_hburst !== 3'd0 || dst_hmastlock !== 1'b0) begin
            n_fail++; $display("FAIL single_ctrl got s=%0d p=%0h b=%0d l=%0b want s=2 p=3 b=0 l=0", dst_hsize, dst_hprot, dst_hburst, dst_hmastlock); end
        @(posedge clk); #1;
        n_chk++; if (dst_hwdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata got %08h want deadbeef", dst_hwdata); end
        wait_drain();
    endtask
    task automatic test_back_to_back();
        int exp_w [6] = '{0, 0, 0, 0, 2, 4};
        ws = 3;
        for (int i = 0; i < 6; i++) begin op_w[i] = 1; op_a[i] = 32'(4 * i); op_d[i] = 32'hA5A50000 + 32'(i); end
        run_ops(6);
        for (int i = 0; i < 6; i++) begin
            n_chk++; if (wt[i] != exp_w[i]) begin n_fail++; $display("FAIL b2b_waits[%0d] got %0d want %0d", i, wt[i], exp_w[i]); end
        end
        wait_drain();
        ws = 0;
    endtask
    task automatic test_read_after_write();
        ws = 0;
        op_w[0] = 1; op_a[0] = 32'h0; op_d[0] = 32'h11112222;
        op_w[1] = 1; op_a[1] = 32'h4; op_d[1] = 32'h33334444;
        op_w[2] = 0; op_a[2] = 32'h0; op_d[2] = 32'h0;
        run_ops(3);
        n_chk++; if (wt[2] != 5) begin n_fail++; $display("FAIL raw_waits got %0d want 5", wt[2]); end
        n_chk++; if (rdv[2] !== 32'h11112222) begin n_fail++; $display("FAIL raw_rdata got %08h want 11112222", rdv[2]); end
        wait_drain();
        op_w[0] = 0; op_a[0] = 32'h4; op_d[0] = 32'h0;
        run_ops(1);
        n_chk++; if (wt[0] != 2) begin n_fail++; $display("FAIL read_waits got %0d want 2", wt[0]); end
        n_chk++; if (rdv[0] !== 32'h33334444) begin n_fail++; $display("FAIL read_rdata got %08h want 33334444", rdv[0]); end
        wait_drain();
    endtask
    task automatic test_posted_error();
        int p0 = pe_hi;
        err_arm = 1;
        op_w[0] = 1; op_a[0] = 32'h2000; op_d[0] = 32'h0BADF00D;
        run_ops(1);
        wait_drain();
        err_arm = 0;
        n_chk++; if (pe_hi - p0 != 1) begin n_fail++; $display("FAIL err_pulse got %0d cycles want 1", pe_hi - p0); end
        n_chk++; if (hresp_bad != 0) begin n_fail++; $display("FAIL src_hresp got %0d nonzero cycles want 0", hresp_bad); end
    endtask
    task automatic test_reset_mid();
        int base;
        ws = 10;
        for (int i = 0; i < 3; i++) begin op_w[i] = 1; op_a[i] = 32'h3000 + 32'(4 * i); op_d[i] = 32'hC0DE0000 + 32'(i); end
        run_ops(3);
        repeat (2) @(posedge clk); #1;
        n_chk++; if (dut.count !== 3'd3) begin n_fail++; $display("FAIL mid_count got %0d want 3", dut.count); end
        rst_n = 0;
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1;
        sb.delete();
        ws = 0;
        base = n_ap;
        repeat (20) @(posedge clk); #1;
        n_chk++; if (n_ap != base) begin n_fail++; $display("FAIL post_rst_activity got %0d want 0", n_ap - base); end
        n_chk++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL post_rst_count got %0d want 0", dut.count); end
        n_chk++; if (src_hready_resp !== 1'b1) begin n_fail++; $display("FAIL post_rst_hready got %0b want 1", src_hready_resp); end
        op_w[0] = 1; op_a[0] = 32'h4000; op_d[0] = 32'h600DCAFE;
        run_ops(1);
        wait_drain();
    endtask
    initial begin
        fork slave_loop(); join_none
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_after_write();
        test_posted_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
